unified_mem_arbiter: RTL

Shares a single unified memory port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the RV32I 5-stage pipeline. The data side has fixed priority, with a starvation guard for fetch. Each request is sequenced through a registered issue/wait/response FSM. Per-requester stall outputs feed the pipeline hazard logic.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/arb_starve_counter.sv | 32 +++
 rtl/unified_mem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, owner tag, byte-enable constant.
// No logic; latency and backpressure live in the modules that import this package.
// Widths here are fixed; data widths stay module parameters.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int BE_MAX_W = 16;
    localparam logic [BE_MAX_W-1:0] BE_ALL = '1;

    // Wide enough for the largest legal starvation limit (15).
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive fetch losses; fetch_force rises once the limit is reached.
// Latency: fetch_force reflects the count registered on the previous arbitration.
// Backpressure: none; inc/clr are single-cycle arbitration events.
module arb_starve_counter
    import arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic fetch_force
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_LIMIT[STARVE_CNT_W-1:0];

    logic [STARVE_CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (clr) begin
            starve_cnt <= '0;
        end else if (inc && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign fetch_force = (starve_cnt >= LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between fetch (read-only) and data (load/store) with data priority.
// Latency: request seen in IDLE -> m_req next cycle -> valid one cycle after m_rvalid (min 3).
// Backpressure: m_req holds until m_gnt; requesters stall until their one-cycle valid pulse.
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
)(
    input  logic                clk,
    input  logic                rst_n,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_valid,
    output logic                i_stall,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                d_stall,

    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state;
    owner_t     owner;
    logic       fetch_force;
    logic       arb_any;
    logic       d_win;
    logic       capture;

    assign arb_any = (state == IDLE) && (i_req || d_req);
    assign d_win   = d_req && (!i_req || !fetch_force);
    // Response data is only accepted once the request has been granted.
    assign capture = m_rvalid && (((state == ISSUE) && m_gnt) || (state == WAIT));

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (arb_any && d_win && i_req),
        .clr         (arb_any && !d_win),
        .fetch_force (fetch_force)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= OWN_I;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state <= ISSUE;
                        m_req <= 1'b1;
                        if (d_win) begin
                            owner   <= OWN_D;
                            m_we    <= d_we;
                            m_be    <= d_be;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            owner   <= OWN_I;
                            m_we    <= 1'b0;
                            m_be    <= BE_ALL[BE_W-1:0];
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (m_gnt) begin
                        m_req <= 1'b0;
                        state <= m_rvalid ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (capture) begin
                if (owner == OWN_D) begin
                    d_rdata <= m_rdata;
                end else begin
                    i_rdata <= m_rdata;
                end
            end
        end
    end

    assign i_valid = (state == RESP) && (owner == OWN_I);
    assign d_valid = (state == RESP) && (owner == OWN_D);
    assign i_stall = i_req && !i_valid;
    assign d_stall = d_req && !d_valid;

endmodule
